entrada_decimal: RTL
====================

Name: entrada_decimal

Overview:
Operator-input block, the inverse of the binary-to-7-segment output path. It collects decimal digits from board switches and push-buttons and assembles them into a 32-bit binary value (acc = acc*10 + digit). It hands that value to the processor's IN instruction through a req/pronto/ack handshake. The running partial value is exported on a separate port so the existing display path can echo it while the operator types.

Parameters:
DEBOUNCE_CICLOS, 50000, cycles a button must be stable before a press is accepted (1 ms at 50 MHz).
BOTAO_ATIVO_BAIXO, 1, 1 = raw buttons are active-low (board keys); 0 = active-high.
MAX_DIGITOS, 5, maximum digits accepted per entry; must be <= 9.

Ports:
clock  input  1  system clock
reset  input  1  asynchronous reset, active-high
chaves  input  4  BCD digit from switches
btn_digito  input  1  raw button: append digit
btn_enter  input  1  raw button: confirm entry
btn_limpa  input  1  raw button: clear entry
req  input  1  level from the CPU; held high while an IN instruction waits
ack  input  1  one-cycle pulse from the CPU; value consumed
valor  output  32  confirmed value, stable while pronto=1
pronto  output  1  confirmed value available
aguardando  output  1  high in state ENTRADA (operator LED)
parcial  output  32  current accumulator, for display

Behaviour:
- Reset (async, active-high): state IDLE, acc=0, ndig=0, valor=0, pronto=0, aguardando=0, all synchronizer and debounce registers cleared. Reset asserted mid-entry discards the entry.
- Button conditioning, per button:
  - Invert if BOTAO_ATIVO_BAIXO=1.
  - 2-FF synchronizer.
  - Debounce counter: reloads on any change of the synchronized level; the level is accepted after DEBOUNCE_CICLOS consecutive stable cycles.
  - Rising edge of the accepted level produces a 1-cycle pulse.
  - Press-to-pulse latency: 2 + DEBOUNCE_CICLOS + 1 cycles. Holding a button yields exactly one pulse.
- chaves is sampled through a 2-FF synchronizer. The value used is the synchronized value in the pulse cycle.
- FSM states:
  - IDLE: pronto=0, aguardando=0. Button pulses are ignored. If req=1, go to ENTRADA next cycle with acc=0, ndig=0.
  - ENTRADA: aguardando=1. Pulse priority in the same cycle is limpa > enter > digito; lower-priority pulses in that cycle are dropped.
    - limpa: acc=0, ndig=0.
    - enter: valor<=acc, pronto<=1, go to PRONTO. With ndig=0 the confirmed value is 0.
    - digito: if chaves<=9 and ndig<MAX_DIGITOS then acc<=acc*10+chaves and ndig++. If chaves>9 or ndig=MAX_DIGITOS, ignore and leave acc unchanged.
    - If req falls while in ENTRADA, abort to IDLE and set acc=0. This check takes precedence over pulses in the same cycle.
  - PRONTO: pronto=1, valor held, button pulses ignored. On ack=1: pronto<=0, acc<=0, ndig<=0, go to IDLE. The ack has effect regardless of req. ack outside PRONTO is ignored.
- Arithmetic:
  - acc is 32-bit unsigned. acc*10 is computed as (acc<<3)+(acc<<1).
  - MAX_DIGITOS<=9 guarantees no overflow; the maximum with the default is 99999, matching the display range.
- parcial = acc, registered, updated the same cycle as acc.
- A new request after ack requires req to be high in IDLE. A req held high continuously re-enters ENTRADA one cycle after the return to IDLE.

Test Plan:
1. DEBOUNCE_CICLOS=4. Assert reset mid-ENTRADA with acc=12 -> all outputs 0 immediately (async), state IDLE after reset release.
2. req=1; digits 4, 0, 7 each via a press held 10 cycles; then enter -> parcial goes 4, 40, 407. Pulse-to-update is 2+4+1 cycles after each press. pronto=1 with valor=407. ack -> pronto=0 the next cycle.
3. Six digits 9 -> parcial=99999 after five; the sixth is ignored. chaves=12 with a digito press -> acc unchanged.
4. Bounce: btn_digito toggles every 2 cycles for 20 cycles, then stable -> exactly one digit appended.
5. enter and limpa pulses in the same cycle with acc=55 -> acc=0, state stays ENTRADA, pronto stays 0. Enter with no digits -> valor=0, pronto=1.
6. req drops during ENTRADA with acc=31 -> IDLE, acc=0, aguardando=0. Button presses in IDLE and PRONTO -> no change to acc or valor.

Source files
------------

// File: rtl/entrada_decimal.sv
// Operator decimal entry: debounced keys build a 32-bit binary value (acc*10 + digit)
// that is handed to the CPU IN instruction through a req/pronto/ack handshake.
module entrada_decimal #(
  parameter int DEBOUNCE_CICLOS   = 50000,
  parameter bit BOTAO_ATIVO_BAIXO = 1'b1,
  parameter int MAX_DIGITOS       = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  chaves,
  input  logic        btn_digito,
  input  logic        btn_enter,
  input  logic        btn_limpa,
  input  logic        req,
  input  logic        ack,
  output logic [31:0] valor,
  output logic        pronto,
  output logic        aguardando,
  output logic [31:0] parcial
);

  localparam int            CW       = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CICLOS);
  localparam logic [3:0]    NDIG_MAX = 4'(MAX_DIGITOS);

  typedef enum logic [1:0] {IDLE, ENTRADA, PRONTO} estado_t;

  function automatic logic [31:0] mul10_soma(input logic [31:0] a, input logic [3:0] d);
    return (a << 3) + (a << 1) + {28'd0, d};
  endfunction

  // Button bit order everywhere: {limpa, enter, digito}
  logic [2:0]    btn_raw;
  logic [2:0]    sinc_p0, sinc_p1;
  logic [2:0]    nivel, estavel, pulso;
  logic [CW-1:0] cnt [3];
  logic [3:0]    chv_p0, chv_p1;

  estado_t     estado, estado_n;
  logic [31:0] acc, acc_n, valor_n;
  logic [3:0]  ndig, ndig_n;
  logic        pronto_n;

  assign btn_raw = {btn_limpa, btn_enter, btn_digito} ^ {3{BOTAO_ATIVO_BAIXO}};

  // Stage p0/p1: two-flop synchronizers, then per-button debounce counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sinc_p0 <= '0;
      sinc_p1 <= '0;
      chv_p0  <= '0;
      chv_p1  <= '0;
      nivel   <= '0;
      estavel <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sinc_p0 <= btn_raw;
      sinc_p1 <= sinc_p0;
      chv_p0  <= chaves;
      chv_p1  <= chv_p0;
      for (int i = 0; i < 3; i++) begin
        if (sinc_p1[i] != nivel[i]) begin
          nivel[i] <= sinc_p1[i];
          cnt[i]   <= CW'(1);
        end else if (cnt[i] != CNT_MAX) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
        if (cnt[i] == CNT_MAX) estavel[i] <= nivel[i];
      end
    end
  end

  // Pulse fires in the cycle the pressed level is first accepted, before estavel follows it
  always_comb begin
    pulso = '0;
    for (int i = 0; i < 3; i++)
      pulso[i] = nivel[i] & ~estavel[i] & (cnt[i] == CNT_MAX);
  end

  always_comb begin
    estado_n = estado;
    acc_n    = acc;
    ndig_n   = ndig;
    valor_n  = valor;
    pronto_n = pronto;
    case (estado)
      IDLE: begin
        if (req) begin
          estado_n = ENTRADA;
          acc_n    = '0;
          ndig_n   = '0;
        end
      end
      ENTRADA: begin
        if (!req) begin
          estado_n = IDLE;
          acc_n    = '0;
          ndig_n   = '0;
        end else if (pulso[2]) begin
          acc_n  = '0;
          ndig_n = '0;
        end else if (pulso[1]) begin
          valor_n  = acc;
          pronto_n = 1'b1;
          estado_n = PRONTO;
        end else if (pulso[0] && chv_p1 <= 4'd9 && ndig < NDIG_MAX) begin
          acc_n  = mul10_soma(acc, chv_p1);
          ndig_n = ndig + 4'd1;
        end
      end
      PRONTO: begin
        if (ack) begin
          pronto_n = 1'b0;
          acc_n    = '0;
          ndig_n   = '0;
          estado_n = IDLE;
        end
      end
      default: estado_n = IDLE;
    endcase
  end

  // Stage p2: FSM state, accumulator and handshake registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= IDLE;
      acc    <= '0;
      ndig   <= '0;
      valor  <= '0;
      pronto <= 1'b0;
    end else begin
      estado <= estado_n;
      acc    <= acc_n;
      ndig   <= ndig_n;
      valor  <= valor_n;
      pronto <= pronto_n;
    end
  end

  assign parcial    = acc;
  assign aguardando = (estado == ENTRADA);

endmodule
